// File: rtl/bitmap_video_scanner.sv
// bitmap_video_scanner
//   Parametrised 1bpp framebuffer scanner for the HDMI path. Generates the
//   display timing, fetches framebuffer bytes from a 1-cycle-latency video
//   RAM, serialises them with independent horizontal/vertical pixel repeat
//   and centres the bitmap in the active area with a border colour.
//
// Ports
//   clk_pixel    pixel clock
//   reset        synchronous, active-high reset
//   dispAddr     registered framebuffer byte address
//   dispData     byte read from dispAddr, valid one clock after the address
//   invert       swap FG/BG, sampled once per frame at counter (0,0)
//   red/green/blue  registered pixel colour
//   hsync/vsync  registered sync, active level SYNC_POL
//   de           registered active-video enable
//   frame_start  one-cycle pulse with output pixel (0,0)
//
// Pipeline: stage 0 is the counter state (hc,vc); stage 1 holds its control
// bits while the RAM answers; the output registers load at the end of stage 1,
// giving a fixed two-cycle latency from counters to pins.
module bitmap_video_scanner #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int          FB_WIDTH   = 256,
    parameter int          FB_HEIGHT  = 256,
    parameter int          H_REP      = 2,
    parameter int          V_REP      = 1,
    parameter logic        LSB_FIRST  = 1'b1,
    parameter int          ADDR_W     = 13,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000,
    parameter logic [23:0] BORDER_RGB = 24'h000040
) (
    input  logic              clk_pixel,
    input  logic              reset,
    output logic [ADDR_W-1:0] dispAddr,
    input  logic [7:0]        dispData,
    input  logic              invert,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int X_OFF   = (H_ACTIVE - FB_WIDTH * H_REP) / 2;
    localparam int Y_OFF   = (V_ACTIVE - FB_HEIGHT * V_REP) / 2;
    localparam int HRW     = (H_REP > 1) ? $clog2(H_REP) : 1;
    localparam int VRW     = (V_REP > 1) ? $clog2(V_REP) : 1;

    localparam logic [HW-1:0] HC_MAX   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HA_LAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] WX_FIRST = HW'(X_OFF);
    localparam logic [HW-1:0] WX_LAST  = HW'(X_OFF + FB_WIDTH * H_REP - 1);
    localparam logic [VW-1:0] VC_MAX   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] WY_FIRST = VW'(Y_OFF);
    localparam logic [VW-1:0] WY_LAST  = VW'(Y_OFF + FB_HEIGHT * V_REP - 1);

    localparam logic [HRW-1:0]    HREP_LAST = HRW'(H_REP - 1);
    localparam logic [VRW-1:0]    VREP_LAST = VRW'(V_REP - 1);
    localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(FB_WIDTH / 8);

    // Bitmap must fit the active area and be made of whole bytes.
    if (H_ACTIVE < FB_WIDTH * H_REP || V_ACTIVE < FB_HEIGHT * V_REP) begin : g_bad_window
        $error("bitmap_video_scanner: bitmap window larger than active area");
    end
    if (FB_WIDTH % 8 != 0) begin : g_bad_width
        $error("bitmap_video_scanner: FB_WIDTH must be a multiple of 8");
    end

    typedef struct packed {
        logic de;   // active video
        logic win;  // inside bitmap window
        logic hs;
        logic vs;
        logic fs;   // counter at (0,0)
        logic ld;   // first cycle of a byte: dispData carries the new byte
        logic px;   // first cycle of a pixel: serialiser advances
    } ctl_t;

    // Stage 0 state
    logic [HW-1:0]     hc, hc_n;
    logic [VW-1:0]     vc, vc_n;
    logic [HRW-1:0]    hrep, hrep_n;      // repeat count within a pixel
    logic [2:0]        bitc, bitc_n;      // pixel index within a byte
    logic [VRW-1:0]    vrep, vrep_n;      // repeat count within a bitmap row
    logic [ADDR_W-1:0] row_base, base_n;  // fy * row bytes for the current line
    logic              win_n, win0;

    // Stage 1 / output state
    ctl_t              ctl0, ctl1;
    logic [7:0]        shreg, shifted;
    logic              inv;
    logic              cur_bit;
    logic [23:0]       pix_rgb;

    // Next counter state. The address register is loaded from this look-ahead
    // so dispAddr already points at a byte while its first pixel is in hc.
    always_comb begin
        hc_n = hc + 1'b1;
        vc_n = vc;
        if (hc == HC_MAX) begin
            hc_n = '0;
            vc_n = (vc == VC_MAX) ? '0 : vc + 1'b1;
        end

        hrep_n = hrep + 1'b1;
        bitc_n = bitc;
        if (hc_n == WX_FIRST) begin
            hrep_n = '0;
            bitc_n = '0;
        end else if (hrep == HREP_LAST) begin
            hrep_n = '0;
            bitc_n = bitc + 1'b1;
        end

        vrep_n = vrep;
        base_n = row_base;
        if (hc_n == '0) begin
            if (vc_n == WY_FIRST) begin
                vrep_n = '0;
                base_n = '0;
            end else if (vc_n > WY_FIRST && vc_n <= WY_LAST) begin
                if (vrep == VREP_LAST) begin
                    vrep_n = '0;
                    base_n = row_base + ROW_BYTES;
                end else begin
                    vrep_n = vrep + 1'b1;
                end
            end
        end

        win_n = (hc_n >= WX_FIRST) && (hc_n <= WX_LAST) &&
                (vc_n >= WY_FIRST) && (vc_n <= WY_LAST);
    end

    // Stage 0 decode
    always_comb begin
        win0     = (hc >= WX_FIRST) && (hc <= WX_LAST) &&
                   (vc >= WY_FIRST) && (vc <= WY_LAST);
        ctl0     = '0;
        ctl0.de  = (hc <= HA_LAST) && (vc <= VA_LAST);
        ctl0.win = win0;
        ctl0.hs  = (hc >= HS_FIRST && hc <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        ctl0.vs  = (vc >= VS_FIRST && vc <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        ctl0.fs  = (hc == '0) && (vc == '0);
        ctl0.ld  = win0 && (hrep == '0) && (bitc == '0);
        ctl0.px  = (hrep == '0);
    end

    // Serialiser: on the load cycle the first pixel comes straight from
    // dispData so the byte is shown two cycles after its address.
    always_comb begin
        shifted = LSB_FIRST ? {1'b0, shreg[7:1]} : {shreg[6:0], 1'b0};
        if (ctl1.ld) begin
            cur_bit = LSB_FIRST ? dispData[0] : dispData[7];
        end else if (ctl1.px) begin
            cur_bit = LSB_FIRST ? shifted[0] : shifted[7];
        end else begin
            cur_bit = LSB_FIRST ? shreg[0] : shreg[7];
        end

        pix_rgb = 24'h000000;
        if (ctl1.de) begin
            if (ctl1.win) begin
                pix_rgb = (cur_bit ^ inv) ? FG_RGB : BG_RGB;
            end else begin
                pix_rgb = BORDER_RGB;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            hrep        <= '0;
            bitc        <= '0;
            vrep        <= '0;
            row_base    <= '0;
            dispAddr    <= '0;
            inv         <= 1'b0;
            shreg       <= '0;
            ctl1        <= '0;
            ctl1.hs     <= ~SYNC_POL;
            ctl1.vs     <= ~SYNC_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else begin
            hc       <= hc_n;
            vc       <= vc_n;
            hrep     <= hrep_n;
            bitc     <= bitc_n;
            vrep     <= vrep_n;
            row_base <= base_n;

            // Hold the address outside the window; step it per byte inside.
            if (win_n) begin
                if (hc_n == WX_FIRST) begin
                    dispAddr <= base_n;
                end else if (hrep_n == '0 && bitc_n == '0) begin
                    dispAddr <= dispAddr + 1'b1;
                end
            end

            if (ctl0.fs) begin
                inv <= invert;
            end

            ctl1 <= ctl0;

            if (ctl1.ld) begin
                shreg <= dispData;
            end else if (ctl1.px) begin
                shreg <= shifted;
            end

            {red, green, blue} <= pix_rgb;
            de          <= ctl1.de;
            frame_start <= ctl1.fs;
            hsync       <= ctl1.hs;
            vsync       <= ctl1.vs;
        end
    end

endmodule

// File: tb/tb_bitmap_video_scanner.sv
// Self-checking bench for bitmap_video_scanner. Two small configurations run
// side by side against a frame-arithmetic reference model; a constant table
// pins down timing edges of configuration A, and short directed sequences
// cover invert latching and a mid-line reset.
module tb_bitmap_video_scanner;

    typedef struct packed {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pol, fbw, fbh, hr, vr, lsb, aw;
    } cfg_t;

    // A: H 40/4/6/6 (56), V 24/2/2/3 (31), 16x8 bitmap, 2x2 repeat, LSB first
    // B: H 30/2/3/2 (37), V 14/1/2/2 (19), 24x4 bitmap, 1x3 repeat, MSB first,
    //    active-high sync, 3-bit address so the address wraps
    localparam cfg_t CA = '{40, 4, 6, 6, 24, 2, 2, 3, 0, 16, 8, 2, 2, 1, 5};
    localparam cfg_t CB = '{30, 2, 3, 2, 14, 1, 2, 2, 1, 24, 4, 1, 3, 0, 3};

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;
    localparam logic [23:0] BORDER = 24'h000040;

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] rgb;
        logic        hs, vs, de, fs;
    } obs_t;

    typedef struct {
        int   n;
        logic de, hs, vs, fs;
    } vec_t;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic       invert = 1'b0;
    logic [4:0] addr_a;
    logic [2:0] addr_b;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;

    logic [7:0] mem [0:255];

    int   vecs = 0;
    int   errs = 0;
    int   n [2];
    int   last [2];
    logic finv [2][0:63];
    logic inv_now = 1'b0;
    vec_t tbl [16];

    always #5 clk_pixel = ~clk_pixel;

    // Video RAM model: one clock of read latency.
    always @(posedge clk_pixel) begin
        data_a <= mem[8'(addr_a)];
        data_b <= mem[8'(addr_b)];
    end

    bitmap_video_scanner #(
        .H_ACTIVE(CA.ha), .H_FP(CA.hfp), .H_SYNC(CA.hsw), .H_BP(CA.hbp),
        .V_ACTIVE(CA.va), .V_FP(CA.vfp), .V_SYNC(CA.vsw), .V_BP(CA.vbp),
        .SYNC_POL(CA.pol[0]), .FB_WIDTH(CA.fbw), .FB_HEIGHT(CA.fbh),
        .H_REP(CA.hr), .V_REP(CA.vr), .LSB_FIRST(CA.lsb[0]), .ADDR_W(CA.aw)
    ) dut_a (
        .clk_pixel(clk_pixel), .reset(reset), .dispAddr(addr_a), .dispData(data_a),
        .invert(invert), .red(r_a), .green(g_a), .blue(b_a), .hsync(hs_a),
        .vsync(vs_a), .de(de_a), .frame_start(fs_a)
    );

    bitmap_video_scanner #(
        .H_ACTIVE(CB.ha), .H_FP(CB.hfp), .H_SYNC(CB.hsw), .H_BP(CB.hbp),
        .V_ACTIVE(CB.va), .V_FP(CB.vfp), .V_SYNC(CB.vsw), .V_BP(CB.vbp),
        .SYNC_POL(CB.pol[0]), .FB_WIDTH(CB.fbw), .FB_HEIGHT(CB.fbh),
        .H_REP(CB.hr), .V_REP(CB.vr), .LSB_FIRST(CB.lsb[0]), .ADDR_W(CB.aw)
    ) dut_b (
        .clk_pixel(clk_pixel), .reset(reset), .dispAddr(addr_b), .dispData(data_b),
        .invert(invert), .red(r_b), .green(g_b), .blue(b_b), .hsync(hs_b),
        .vsync(vs_b), .de(de_b), .frame_start(fs_b)
    );

    // ---------------- reference model ----------------
    function automatic cfg_t cfg_of(int d);
        return (d == 0) ? CA : CB;
    endfunction

    function automatic int htot(cfg_t c);
        return c.ha + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int vtot(cfg_t c);
        return c.va + c.vfp + c.vsw + c.vbp;
    endfunction

    function automatic bit in_win(cfg_t c, int h, int v);
        int xo = (c.ha - c.fbw * c.hr) / 2;
        int yo = (c.va - c.fbh * c.vr) / 2;
        return h >= xo && h < xo + c.fbw * c.hr && v >= yo && v < yo + c.fbh * c.vr;
    endfunction

    // Byte address of the pixel (h,v): row * bytes-per-row + byte column, wrapped.
    function automatic int win_addr(cfg_t c, int h, int v);
        int xo = (c.ha - c.fbw * c.hr) / 2;
        int yo = (c.va - c.fbh * c.vr) / 2;
        return (((v - yo) / c.vr) * (c.fbw / 8) + (h - xo) / (8 * c.hr)) % (1 << c.aw);
    endfunction

    // Output at cycle n shows the screen position the counters held at n-2.
    function automatic obs_t expect_obs(int d);
        cfg_t c = cfg_of(d);
        obs_t o;
        int q, h, v, fi, k;
        logic [7:0] byt;
        logic pbit, ivf;
        o.addr = 8'(last[d]);
        o.rgb  = 24'h0;
        o.hs   = ~c.pol[0];
        o.vs   = ~c.pol[0];
        o.de   = 1'b0;
        o.fs   = 1'b0;
        if (n[d] < 2) return o;
        q  = n[d] - 2;
        h  = q % htot(c);
        v  = (q / htot(c)) % vtot(c);
        fi = q / (htot(c) * vtot(c));
        o.de = (h < c.ha) && (v < c.va);
        o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.pol[0] : ~c.pol[0];
        o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.pol[0] : ~c.pol[0];
        o.fs = (h == 0) && (v == 0);
        if (o.de) begin
            if (in_win(c, h, v)) begin
                byt  = mem[win_addr(c, h, v)];
                k    = ((h - (c.ha - c.fbw * c.hr) / 2) / c.hr) % 8;
                pbit = c.lsb[0] ? byt[k] : byt[7 - k];
                ivf  = (fi < 64) ? finv[d][fi] : 1'b0;
                o.rgb = (pbit ^ ivf) ? FG : BG;
            end else begin
                o.rgb = BORDER;
            end
        end
        return o;
    endfunction

    function automatic obs_t obs_of(int d);
        obs_t o;
        if (d == 0) begin
            o.addr = 8'(addr_a); o.rgb = {r_a, g_a, b_a};
            o.hs = hs_a; o.vs = vs_a; o.de = de_a; o.fs = fs_a;
        end else begin
            o.addr = 8'(addr_b); o.rgb = {r_b, g_b, b_b};
            o.hs = hs_b; o.vs = vs_b; o.de = de_b; o.fs = fs_b;
        end
        return o;
    endfunction

    task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d n=%0d: got %0h want %0h", nm, d, n[d], act, exp);
        end
    endtask

    task automatic check_all();
        obs_t e, a;
        for (int d = 0; d < 2; d++) begin
            e = expect_obs(d);
            a = obs_of(d);
            cmp("addr", d, 32'(a.addr), 32'(e.addr));
            cmp("rgb",  d, 32'(a.rgb),  32'(e.rgb));
            cmp("hsync", d, 32'(a.hs),  32'(e.hs));
            cmp("vsync", d, 32'(a.vs),  32'(e.vs));
            cmp("de",    d, 32'(a.de),  32'(e.de));
            cmp("frame_start", d, 32'(a.fs), 32'(e.fs));
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check.
    task automatic tick(input logic r, input logic iv);
        cfg_t c;
        int h, v, ft;
        reset  = r;
        invert = iv;
        for (int d = 0; d < 2; d++) begin
            c  = cfg_of(d);
            ft = htot(c) * vtot(c);
            if (!r && n[d] % ft == 0 && n[d] / ft < 64) finv[d][n[d] / ft] = iv;
        end
        @(posedge clk_pixel);
        for (int d = 0; d < 2; d++) begin
            c = cfg_of(d);
            if (r) begin
                n[d] = 0;
                last[d] = 0;
            end else begin
                n[d]++;
            end
            h = n[d] % htot(c);
            v = (n[d] / htot(c)) % vtot(c);
            if (in_win(c, h, v)) last[d] = win_addr(c, h, v);
        end
        @(negedge clk_pixel);
        check_all();
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (n[0] < target && g < 5000) begin
            tick(1'b0, inv_now);
            g++;
        end
        if (n[0] != target) begin
            vecs++;
            errs++;
            $display("FAIL run_to: reached n=%0d want %0d", n[0], target);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < 16; i++) begin
            run_to(tbl[i].n);
            cmp("tbl_de",    0, 32'(de_a), 32'(tbl[i].de));
            cmp("tbl_hsync", 0, 32'(hs_a), 32'(tbl[i].hs));
            cmp("tbl_vsync", 0, 32'(vs_a), 32'(tbl[i].vs));
            cmp("tbl_fs",    0, 32'(fs_a), 32'(tbl[i].fs));
        end
    endtask

    initial begin
        // cycle after reset edge, de, hsync, vsync, frame_start (config A, sync active low)
        tbl[0]  = '{0,    0, 1, 1, 0};
        tbl[1]  = '{1,    0, 1, 1, 0};
        tbl[2]  = '{2,    1, 1, 1, 1};
        tbl[3]  = '{3,    1, 1, 1, 0};
        tbl[4]  = '{41,   1, 1, 1, 0};
        tbl[5]  = '{42,   0, 1, 1, 0};
        tbl[6]  = '{45,   0, 1, 1, 0};
        tbl[7]  = '{46,   0, 0, 1, 0};
        tbl[8]  = '{51,   0, 0, 1, 0};
        tbl[9]  = '{52,   0, 1, 1, 0};
        tbl[10] = '{58,   1, 1, 1, 0};
        tbl[11] = '{1457, 0, 1, 1, 0};
        tbl[12] = '{1458, 0, 1, 0, 0};
        tbl[13] = '{1514, 0, 1, 0, 0};
        tbl[14] = '{1570, 0, 1, 1, 0};
        tbl[15] = '{1738, 1, 1, 1, 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int d = 0; d < 2; d++) begin
            n[d] = 0;
            last[d] = 0;
            for (int f = 0; f < 64; f++) finv[d][f] = 1'b0;
        end

        @(negedge clk_pixel);
        repeat (3) tick(1'b1, 1'b0);

        // Timing edges from reset release, random bitmap checked by the model.
        run_table();

        // Invert raised mid-frame: current frame unchanged, next frame swapped.
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        inv_now = 1'b0;
        tick(1'b1, inv_now);
        run_to(12 * 56);
        inv_now = 1'b1;
        run_to(734);
        cmp("inv_same_frame", 0, 32'({r_a, g_a, b_a}), 32'(BG));
        run_to(1783);
        cmp("inv_blank", 0, 32'({r_a, g_a, b_a}), 32'h0);
        run_to(1962);
        cmp("inv_border", 0, 32'({r_a, g_a, b_a}), 32'(BORDER));
        run_to(1966);
        cmp("inv_next_frame", 0, 32'({r_a, g_a, b_a}), 32'(FG));

        // One-cycle reset in the middle of a line, then timing restarts.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        tick(1'b1, inv_now);
        run_to(3 * 56 + 20);
        tick(1'b1, inv_now);
        cmp("rst_de", 0, 32'(de_a), 32'h0);
        cmp("rst_fs", 0, 32'(fs_a), 32'h0);
        cmp("rst_rgb", 0, 32'({r_a, g_a, b_a}), 32'h0);
        cmp("rst_hsync", 0, 32'(hs_a), 32'h1);
        cmp("rst_addr", 0, 32'(addr_a), 32'h0);
        cmp("rst_hsync_b", 1, 32'(hs_b), 32'h0);
        run_table();

        // Random invert toggles and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(199) == 0) inv_now = ~inv_now;
            tick(($urandom_range(2499) == 0) ? 1'b1 : 1'b0, inv_now);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
